// File: rtl/adt7320_pkg.sv
// Shared definitions for the ADT7320-style SPI register responder.
package adt7320_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CONFIG = 3'd1;
    localparam logic [2:0] ADDR_TEMP   = 3'd2;
    localparam logic [2:0] ADDR_ID     = 3'd3;

    localparam logic [7:0] ID_DEFAULT  = 8'hC3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Index of the final data bit: the temperature word is 16 bits, all others 8.
    function automatic logic [3:0] last_bit(input logic [2:0] addr);
        return (addr == ADDR_TEMP) ? 4'd15 : 4'd7;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for cs/sclk/din plus cs-fall and sclk rise/fall strobes.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclk,
    input  logic din,
    output logic cs_s,
    output logic din_s,
    output logic cs_fall,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [1:0] cs_q, sclk_q, din_q;
    logic       cs_prev_q, sclk_prev_q;
    logic [2:0] fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q        <= '1;
            sclk_q      <= '1;
            din_q       <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            fill_q      <= '0;
        end else begin
            cs_q        <= {cs_q[0], cs};
            sclk_q      <= {sclk_q[0], sclk};
            din_q       <= {din_q[0], din};
            cs_prev_q   <= cs_q[1];
            sclk_prev_q <= sclk_q[1];
            fill_q      <= {fill_q[1:0], 1'b1};
        end
    end

    // Edges are only trusted once the pipeline holds real samples, so a cs
    // held low across reset does not look like a fresh falling edge.
    assign cs_s      = cs_q[1];
    assign din_s     = din_q[1];
    assign cs_fall   = fill_q[2] &  cs_prev_q   & ~cs_q[1];
    assign sclk_rise = fill_q[2] & ~sclk_prev_q &  sclk_q[1];
    assign sclk_fall = fill_q[2] &  sclk_prev_q & ~sclk_q[1];

endmodule

// File: rtl/adt7320_responder.sv
// SPI mode-3 register responder (config/temp/ID). Define ADT7320_SWRESET_EN to
// enable the 32-ones software reset.
module adt7320_responder
    import adt7320_pkg::*;
#(
    parameter logic [7:0] ID_VALUE     = ID_DEFAULT,
    parameter logic [7:0] CONFIG_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        sclk,
    input  logic        din,
    output logic        dout,
    output logic        dout_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_out,
    output logic        xfer_done
);

    logic cs_s, din_s, cs_fall, sclk_rise, sclk_fall;

    spi_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .din       (din),
        .cs_s      (cs_s),
        .din_s     (din_s),
        .cs_fall   (cs_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  last_q, last_d;
    logic [6:0]  sr_q, sr_d;
    logic        rd_q, rd_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] temp_sh_q, temp_sh_d;
    logic [7:0]  config_q, config_d;
    logic        dout_q, dout_d;
    logic        xfer_done_q, xfer_done_d;
    logic [15:0] rdata;
    logic        swrst;

`ifdef ADT7320_SWRESET_EN
    logic [4:0] ones_q, ones_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ones_q <= '0;
        else        ones_q <= ones_d;
    end

    always_comb begin
        ones_d = ones_q;
        if (state_q == IDLE || cs_s || (sclk_rise && !din_s)) ones_d = '0;
        else if (sclk_rise)                                   ones_d = ones_q + 5'd1;
    end

    assign swrst = sclk_rise && din_s && (ones_q == 5'd31) && (state_q != IDLE) && !cs_s;
`else
    assign swrst = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            last_q      <= '0;
            sr_q        <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            temp_sh_q   <= '0;
            config_q    <= CONFIG_RESET;
            dout_q      <= 1'b1;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            last_q      <= last_d;
            sr_q        <= sr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            temp_sh_q   <= temp_sh_d;
            config_q    <= config_d;
            dout_q      <= dout_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            ADDR_CONFIG: rdata = {config_q, 8'h00};
            ADDR_TEMP:   rdata = temp_sh_q;
            ADDR_ID:     rdata = {ID_VALUE, 8'h00};
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        last_d      = last_q;
        sr_d        = sr_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        temp_sh_d   = temp_sh_q;
        config_d    = config_q;
        dout_d      = dout_q;
        xfer_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                dout_d    = 1'b1;
                if (cs_fall) state_d = CMD;
            end
            CMD: begin
                dout_d = 1'b1;
                if (sclk_rise) begin
                    sr_d      = {sr_q[5:0], din_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Command byte is {sr_q[6:0], din_s}: bit6 read, bits5:3 address.
                    if (bit_cnt_q == 4'd7) begin
                        rd_d      = sr_q[5];
                        addr_d    = sr_q[4:2];
                        last_d    = last_bit(sr_q[4:2]);
                        temp_sh_d = temp_in;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (!rd_q)          dout_d = 1'b1;
                else if (sclk_fall) dout_d = rdata[4'd15 - bit_cnt_q];
                if (sclk_rise) begin
                    sr_d      = {sr_q[5:0], din_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == last_q) begin
                        state_d     = CMD;
                        bit_cnt_d   = '0;
                        xfer_done_d = 1'b1;
                        if (!rd_q && addr_q == ADDR_CONFIG) config_d = {sr_q[6:0], din_s};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (swrst) begin
            config_d    = CONFIG_RESET;
            state_d     = CMD;
            bit_cnt_d   = '0;
            xfer_done_d = 1'b0;
        end

        // cs high wins over everything, including a data phase finishing this cycle.
        if (state_q != IDLE && cs_s) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            dout_d      = 1'b1;
            xfer_done_d = 1'b0;
            config_d    = config_q;
        end
    end

    assign dout       = dout_q;
    assign dout_oe    = (state_q != IDLE) && !cs_s;
    assign config_out = config_q;
    assign xfer_done  = xfer_done_q;

endmodule
